// File: rtl/work_sched_pkg.sv
// work_sched_pkg: shared FSM state encoding and ID-width helper for work_rest_scheduler
package work_sched_pkg;
  typedef enum logic [1:0] {SLEEPING = 2'd0, WORKING = 2'd1, RESTING = 2'd2} sched_state_e;
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick; req/ptr in, winner idx and any out
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          any
);
  // Lowest set bit overall is the wrap-around fallback; the lowest set bit at or above ptr overrides it.
  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) if (req[i]) idx = IW'(i);
    for (int i = N - 1; i >= 0; i--) if (req[i] && i >= int'(ptr)) idx = IW'(i);
    any = |req;
  end
endmodule

// File: rtl/work_rest_scheduler.sv
// work_rest_scheduler: round-robin time-share of one engine with capped bursts and mandatory rest; ports clk/rst, req/halt in, gnt/gnt_id/gnt_valid/state/preempted out
module work_rest_scheduler
  import work_sched_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WORK_MAX    = 8,
  parameter int REST_CYCLES = 2,
  localparam int IW = id_width(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             halt,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    gnt_id,
  output logic             gnt_valid,
  output logic [1:0]       state,
  output logic             preempted
);
  localparam int BW = $clog2(WORK_MAX + 1);
  localparam int RW = $clog2(REST_CYCLES + 1);
  sched_state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, own_q, own_d, win;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic pre_q, pre_d, any, grant;
  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (.req(req), .ptr(ptr_q), .idx(win), .any(any));
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    bcnt_d  = bcnt_q;
    rcnt_d  = rcnt_q;
    pre_d   = 1'b0;
    grant   = 1'b0;
    case (state_q)
      SLEEPING: grant = !halt && any;
      WORKING:
        if (halt) state_d = SLEEPING;
        else if (!req[own_q] || bcnt_q == BW'(WORK_MAX - 1)) begin
          state_d = RESTING;
          rcnt_d  = '0;
          // a release in the same cycle as expiry counts as a normal release
          pre_d   = req[own_q];
        end else bcnt_d = bcnt_q + 1'b1;
      RESTING:
        if (halt) state_d = SLEEPING;
        else if (rcnt_q == RW'(REST_CYCLES - 1)) begin
          state_d = SLEEPING;
          grant   = any;
        end else rcnt_d = rcnt_q + 1'b1;
      default: state_d = SLEEPING;
    endcase
    if (grant) begin
      state_d = WORKING;
      own_d   = win;
      ptr_d   = (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
      bcnt_d  = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SLEEPING;
      ptr_q   <= '0;
      own_q   <= '0;
      bcnt_q  <= '0;
      rcnt_q  <= '0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      bcnt_q  <= bcnt_d;
      rcnt_q  <= rcnt_d;
      pre_q   <= pre_d;
    end
  end
  assign gnt       = (state_q == WORKING) ? (N_REQ'(1) << own_q) : '0;
  assign gnt_valid = (state_q == WORKING);
  assign gnt_id    = own_q;
  assign state     = state_q;
  assign preempted = pre_q;
endmodule

// File: tb/tb_work_rest_scheduler.sv
// tb_work_rest_scheduler: directed self-checking bench for work_rest_scheduler (N_REQ=4, WORK_MAX=8, REST_CYCLES=2)
module tb_work_rest_scheduler;
  logic clk = 1'b0, rst = 1'b1, halt = 1'b0;
  logic [3:0] req = '0, gnt;
  logic [1:0] gnt_id, state;
  logic gnt_valid, preempted;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  work_rest_scheduler #(.N_REQ(4), .WORK_MAX(8), .REST_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req(req), .halt(halt), .gnt(gnt), .gnt_id(gnt_id),
    .gnt_valid(gnt_valid), .state(state), .preempted(preempted)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic restart();
    rst = 1'b1;
    req = '0;
    halt = 1'b0;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    int cyc;
    int ord[6] = '{0, 1, 3, 0, 1, 3};
    // budget expiry; also reset values
    restart();
    check("rst state", state, 0);
    check("rst gnt", gnt, 0);
    check("rst gnt_valid", gnt_valid, 0);
    check("rst gnt_id", gnt_id, 0);
    check("rst preempted", preempted, 0);
    req = 4'b0100;
    for (int t = 1; t <= 11; t++) begin
      tick();
      check($sformatf("exp gnt c%0d", t), gnt, (t <= 8 || t == 11) ? 4'b0100 : 4'b0000);
      check($sformatf("exp state c%0d", t), state, (t <= 8 || t == 11) ? 1 : 2);
      check($sformatf("exp pre c%0d", t), preempted, (t == 9) ? 1 : 0);
    end
    // round robin over 1011
    restart();
    req = 4'b1011;
    cyc = 0;
    for (int k = 0; k < 6; k++) begin
      while (cyc < 1 + 10 * k) begin tick(); cyc++; end
      check($sformatf("rr id b%0d", k), gnt_id, ord[k]);
      check($sformatf("rr gnt b%0d", k), gnt, 32'(1) << ord[k]);
      check($sformatf("rr valid b%0d", k), gnt_valid, 1);
      while (cyc < 9 + 10 * k) begin tick(); cyc++; end
      check($sformatf("rr gap1 b%0d", k), gnt, 0);
      check($sformatf("rr pre b%0d", k), preempted, 1);
      tick(); cyc++;
      check($sformatf("rr gap2 b%0d", k), state, 2);
    end
    // early release
    restart();
    req = 4'b0010;
    for (int t = 1; t <= 8; t++) begin
      if (t == 4) begin tick(); req = 4'b0000; end else tick();
      check($sformatf("rel gnt c%0d", t), gnt, (t <= 4) ? 4'b0010 : 4'b0000);
      check($sformatf("rel state c%0d", t), state, (t <= 4) ? 1 : (t <= 6) ? 2 : 0);
      check($sformatf("rel pre c%0d", t), preempted, 0);
    end
    // halt in third working cycle, then halt blocks grants
    restart();
    req = 4'b1111;
    tick(); tick(); tick();
    check("halt pre gnt", gnt, 4'b0001);
    halt = 1'b1;
    tick();
    check("halt state", state, 0);
    check("halt gnt", gnt, 0);
    for (int t = 5; t <= 7; t++) begin
      tick();
      check($sformatf("halt hold c%0d", t), gnt, 0);
    end
    halt = 1'b0;
    tick();
    check("halt resume id", gnt_id, 1);
    check("halt resume gnt", gnt, 4'b0010);
    // asynchronous reset mid-burst
    restart();
    req = 4'b0100;
    tick(); tick();
    check("arst pre gnt", gnt, 4'b0100);
    #2 rst = 1'b1;
    #1;
    check("arst gnt", gnt, 0);
    check("arst valid", gnt_valid, 0);
    check("arst state", state, 0);
    check("arst id", gnt_id, 0);
    tick();
    rst = 1'b0;
    req = 4'b1100;
    tick();
    check("arst regrant id", gnt_id, 2);
    check("arst regrant gnt", gnt, 4'b0100);
    // release coincides with budget expiry
    restart();
    req = 4'b0001;
    repeat (8) tick();
    check("sim last gnt", gnt, 4'b0001);
    req = 4'b0000;
    tick();
    check("sim state", state, 2);
    check("sim pre", preempted, 0);
    check("sim gnt", gnt, 0);
    // halt coincides with budget expiry
    restart();
    req = 4'b0001;
    repeat (8) tick();
    halt = 1'b1;
    tick();
    check("hexp state", state, 0);
    check("hexp pre", preempted, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/work_rest_scheduler.md
# work_rest_scheduler

Time-shares one resource among `N_REQ` requesters through a three-state power/duty FSM: SLEEPING, WORKING and RESTING. A round-robin arbiter picks the next owner. Each ownership burst is capped at `WORK_MAX` cycles. Every burst is followed by a mandatory `REST_CYCLES` cooldown. The block sits between the requesting agents and the shared engine, and drives the engine's select/enable.

## Interface
- `N_REQ`, 4 — number of requesters; range 2..16, need not be a power of two.
- `WORK_MAX`, 8 — maximum consecutive grant cycles per burst; must be ≥1.
- `REST_CYCLES`, 2 — cooldown length after every burst; must be ≥1.
- `clk`  input  1  — single clock, rising edge.
- `rst`  input  1  — asynchronous, active-high reset.
- `req`  input  N_REQ  — level request per requester; held while the requester wants the resource.
- `halt`  input  1  — forces return to SLEEPING; highest priority.
- `gnt`  output  N_REQ  — one-hot grant, asserted only in WORKING.
- `gnt_id`  output  max(1,$clog2(N_REQ))  — index of the current/last owner.
- `gnt_valid`  output  1  — equals `|gnt`.
- `state`  output  2  — SLEEPING=0, WORKING=1, RESTING=2; 3 is unused.
- `preempted`  output  1  — one-cycle pulse in the first RESTING cycle when the burst ended on budget expiry.

## Operation
- Reset values: `state`=SLEEPING, `gnt`=0, `gnt_valid`=0, `gnt_id`=0, `preempted`=0. RR pointer and all counters are 0.
- All outputs decode registered state only; no combinational path from `req` or `halt` to any output.
- **Arbitration:** the winner is the first set `req` bit at index ≥ pointer, wrapping circularly. When a winner is granted, pointer := (winner+1) mod N_REQ, including for non-power-of-two `N_REQ`.
- **SLEEPING:** if `halt`=0 and `req`≠0, go to WORKING with the arbitration winner as owner; otherwise stay.
- **WORKING:** `gnt[owner]`=1. The burst counter counts 0..WORK_MAX-1. Exit conditions, in priority order:
  - `halt`=1 → SLEEPING.
  - `req[owner]`=0 → RESTING (normal release).
  - counter = WORK_MAX-1 → RESTING, and set `preempted` for the next cycle.
- **RESTING:** `gnt`=0. The rest counter counts 0..REST_CYCLES-1. Exit conditions, in priority order:
  - `halt`=1 → SLEEPING.
  - In the last rest cycle, `req`≠0 → WORKING with a new arbitration.
  - In the last rest cycle, `req`=0 → SLEEPING.
- Transition into WORKING clears the burst counter; transition into RESTING clears the rest counter.
- `gnt_id` is updated only on entry to WORKING and holds its value otherwise.
- Requests from non-owners during WORKING or RESTING are ignored until the next arbitration point. Requests are not latched.

## Timing
- Grant latency: a `req` sampled at the edge ending cycle t (in SLEEPING) gives `gnt` high in cycle t+1.
- A burst lasts at most WORK_MAX cycles; `gnt` is never high for WORK_MAX+1 consecutive cycles.
- Release latency: if the owner drops `req` in cycle t, `gnt` remains high in cycle t and drops in t+1. This one-cycle overhang is mandatory.
- RESTING lasts exactly REST_CYCLES cycles unless halted.
- Minimum gap between two bursts: REST_CYCLES cycles with `gnt`=0.
- Simultaneous release and budget expiry in the same cycle → normal release, no `preempted` pulse.
- `halt` with release or expiry in the same cycle → SLEEPING, no `preempted` pulse.
- `halt` in SLEEPING blocks any grant. The pointer advances only on actual grants.
- `rst` mid-burst: `gnt` drops asynchronously and everything returns to reset values. The first grant after reset starts from pointer 0.

## Structure
- Package `work_sched_pkg` holds:
  - enum `sched_state_e` (SLEEPING/WORKING/RESTING, 2-bit, encodings above);
  - the function computing the ID width.
- Sub-module `rr_pick`: purely combinational; inputs `req` and `ptr`, outputs winner index and `any`.
- Counter widths: $clog2(WORK_MAX+1) for the burst counter and $clog2(REST_CYCLES+1) for the rest counter.

## Test plan
1. Budget expiry (N_REQ=4, WORK_MAX=8, REST_CYCLES=2): `req`=4'b0100 held from cycle 0.
   - Expect `gnt`=4'b0100 in cycles 1–8, RESTING in 9–10, `preempted` only in cycle 9, `gnt` again from 11.
2. Round robin: `req`=4'b1011 held continuously.
   - Expect grant order 0,1,3,0,1,3 with `gnt_id` matching and a 2-cycle gap between bursts.
3. Early release: `req[1]` high in cycles 0–3, then low.
   - Expect `gnt[1]` high in cycles 1–4, RESTING 5–6, SLEEPING from 7, `preempted` never set.
4. Halt: assert `halt` in the 3rd WORKING cycle.
   - Expect `gnt`=0 and `state`=SLEEPING the next cycle; no grant while `halt` stays high even with `req`=4'b1111.
5. Reset mid-burst: assert `rst` during WORKING with owner 2.
   - Expect all outputs 0 immediately (asynchronously); after release, `req`=4'b1100 grants index 2 first (pointer is back at 0).
6. Simultaneous events: owner drops `req` exactly in burst cycle 8.
   - Expect RESTING with `preempted`=0.
